// File: rtl/mux_2x1_pkg.sv
// Shared constants for the mux_2x1 slice: default data width and the
// switch-counter width/saturation value used when MUX_2X1_SWITCH_CNT_EN is defined.
package mux_2x1_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam int SW_CNT_W = 16;
  localparam logic [SW_CNT_W-1:0] SW_CNT_MAX = {SW_CNT_W{1'b1}};

  // Saturating increment: sticks at SW_CNT_MAX instead of wrapping to zero.
  function automatic logic [SW_CNT_W-1:0] sat_inc(input logic [SW_CNT_W-1:0] v);
    return (v == SW_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mux_2x1_sw_cnt.sv
// Saturating count of registered select switches; only instantiated by
// mux_2x1 when MUX_2X1_SWITCH_CNT_EN is defined.
module mux_2x1_sw_cnt
  import mux_2x1_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sel,
  input  logic                sel_q,
  output logic [SW_CNT_W-1:0] cnt
);

  // A switch is a capture whose new select differs from the one held in sel_q.
  logic is_switch;
  assign is_switch = en && (sel != sel_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (is_switch) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/mux_2x1.sv
// N-bit 2-to-1 mux with combinational output y and an enable-gated registered
// copy (y_q/sel_q). Define MUX_2X1_SWITCH_CNT_EN to add the switch_cnt output.
module mux_2x1
  import mux_2x1_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        a,
  input  logic [N-1:0]        b,
  input  logic                sel,
  input  logic                en,
  output logic [N-1:0]        y,
  output logic [N-1:0]        y_q,
  output logic                sel_q
`ifdef MUX_2X1_SWITCH_CNT_EN
  ,
  output logic [SW_CNT_W-1:0] switch_cnt
`endif
);

  // y never depends on clk, rst or en.
  always_comb begin
    y = sel ? b : a;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= '0;
      sel_q <= 1'b0;
    end else if (en) begin
      y_q   <= y;
      sel_q <= sel;
    end
  end

`ifdef MUX_2X1_SWITCH_CNT_EN
  mux_2x1_sw_cnt u_sw_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .sel   (sel),
    .sel_q (sel_q),
    .cnt   (switch_cnt)
  );
`endif

endmodule

// File: tb/tb_mux_2x1.sv
// Directed bench for mux_2x1: a behavioural model feeds an expected queue that
// is checked every cycle, plus hand-computed literal checks on key vectors.
module tb_mux_2x1;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sel;
  logic         en;
  logic [N-1:0] y;
  logic [N-1:0] y_q;
  logic         sel_q;
`ifdef MUX_2X1_SWITCH_CNT_EN
  logic [15:0]  switch_cnt;
`endif

  int checks_total = 0;
  int checks_pass  = 0;

  mux_2x1 #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .sel   (sel),
    .en    (en),
    .y     (y),
    .y_q   (y_q),
    .sel_q (sel_q)
`ifdef MUX_2X1_SWITCH_CNT_EN
    ,
    .switch_cnt (switch_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    a   = '0;
    b   = '0;
    sel = 1'b0;
  end

  // model: registered state per the capture rules, pushed once per edge
  logic [N-1:0] m_y_q;
  logic         m_sel_q;
  int unsigned  m_cnt;
  logic [N:0]   exp_q[$];
  int unsigned  exp_cnt_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_y_q   = '0;
      m_sel_q = 1'b0;
      m_cnt   = 0;
    end else if (en) begin
      if (sel != m_sel_q && m_cnt < 65535) m_cnt = m_cnt + 1;
      m_y_q   = (sel == 1'b1) ? b : a;
      m_sel_q = sel;
    end
    exp_q.push_back({m_sel_q, m_y_q});
    exp_cnt_q.push_back(m_cnt);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // scoreboard: compare at negedge, away from the active edge
  always @(negedge clk) begin
    logic [N:0]  e;
    int unsigned ec;
    check("y_comb", 32'(y), (sel == 1'b1) ? 32'(b) : 32'(a));
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ec = exp_cnt_q.pop_front();
      check("y_q_model", 32'(y_q), 32'(e[N-1:0]));
      check("sel_q_model", 32'(sel_q), 32'(e[N]));
`ifdef MUX_2X1_SWITCH_CNT_EN
      check("switch_cnt_model", 32'(switch_cnt), ec);
`else
      if (ec > 65535) check("model_cnt_range", ec, 32'd65535);
`endif
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [N-1:0] na, input logic [N-1:0] nb,
                       input logic nsel, input logic nen, input logic nrst);
    a   = na;
    b   = nb;
    sel = nsel;
    en  = nen;
    rst = nrst;
    #1;
  endtask

  initial begin
    tick();
    tick();
    check("reset_y_q", 32'(y_q), 32'h0);
    check("reset_sel_q", 32'(sel_q), 32'h0);

    drive(8'hAA, 8'h55, 1'b0, 1'b1, 1'b0);
    check("y_sel0", 32'(y), 32'hAA);
    tick();
    check("y_q_aa", 32'(y_q), 32'hAA);
    check("sel_q_0", 32'(sel_q), 32'h0);

    drive(8'hAA, 8'h55, 1'b1, 1'b1, 1'b0);
    check("y_sel1_same_step", 32'(y), 32'h55);
    check("y_q_before_edge", 32'(y_q), 32'hAA);
    tick();
    check("y_q_55", 32'(y_q), 32'h55);
    check("sel_q_1", 32'(sel_q), 32'h1);

    drive(8'hF0, 8'h0F, 1'b1, 1'b1, 1'b0);
    check("y_0f", 32'(y), 32'h0F);
    tick();
    check("y_q_0f", 32'(y_q), 32'h0F);
    drive(8'hF0, 8'h0F, 1'b0, 1'b1, 1'b0);
    check("y_f0", 32'(y), 32'hF0);
    tick();
    check("y_q_f0", 32'(y_q), 32'hF0);
    check("sel_q_f0", 32'(sel_q), 32'h0);

    // en=0: y follows, registers hold
    drive(8'h12, 8'h34, 1'b1, 1'b0, 1'b0);
    check("y_en0", 32'(y), 32'h34);
    tick();
    check("hold_y_q", 32'(y_q), 32'hF0);
    check("hold_sel_q", 32'(sel_q), 32'h0);
    drive(8'h56, 8'h34, 1'b0, 1'b0, 1'b0);
    check("y_en0_b", 32'(y), 32'h56);
    tick();
    check("hold_y_q2", 32'(y_q), 32'hF0);

    drive(8'h56, 8'h34, 1'b1, 1'b1, 1'b0);
    tick();
    check("y_q_34", 32'(y_q), 32'h34);

    // rst with en=1: rst wins, y unaffected
    drive(8'h77, 8'h34, 1'b0, 1'b1, 1'b1);
    check("y_during_rst", 32'(y), 32'h77);
    check("y_q_rst_not_yet", 32'(y_q), 32'h34);
    tick();
    check("y_q_rst_wins", 32'(y_q), 32'h0);
    check("sel_q_rst_wins", 32'(sel_q), 32'h0);
    drive(8'h77, 8'h34, 1'b0, 1'b1, 1'b0);
    tick();
    check("y_q_77", 32'(y_q), 32'h77);

    // rst pulse between edges: no effect
    drive(8'h77, 8'h34, 1'b0, 1'b0, 1'b1);
    check("y_q_rst_pulse_mid", 32'(y_q), 32'h77);
    rst = 1'b0;
    tick();
    check("y_q_rst_pulse_after", 32'(y_q), 32'h77);

    // a few more directed vectors, model-checked
    for (int i = 0; i < 8; i++) begin
      drive(8'(i * 37 + 1), 8'(255 - i * 19), 1'(i % 2), 1'(i != 5), 1'b0);
      tick();
    end

`ifdef MUX_2X1_SWITCH_CNT_EN
    drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    tick();
    check("cnt_reset", 32'(switch_cnt), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(8'h00, 8'h00, 1'((i + 1) % 2), 1'b1, 1'b0);
      tick();
    end
    check("cnt_five", 32'(switch_cnt), 32'd5);
    for (int i = 0; i < 65540; i++) begin
      sel = ~sel;
      tick();
    end
    check("cnt_saturated", 32'(switch_cnt), 32'hFFFF);
    drive(8'h00, 8'h00, sel, 1'b1, 1'b1);
    tick();
    check("cnt_cleared", 32'(switch_cnt), 32'h0);
    rst = 1'b0;
`endif

    tick();
    tick();
    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
